// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift_deser serial-to-parallel receiver.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_if.sv
// Serial-in / parallel-out bus of shift_deser.
// SHIFT_DESER_PARITY_EN adds the parity_err signal.
interface shift_deser_if #(
    parameter int WIDTH = 8
);
    logic             dir;
    logic             ser_valid;
    logic             ser_in;
    logic             ser_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             busy;
`ifdef SHIFT_DESER_PARITY_EN
    logic             parity_err;
`endif

    // master = bit producer plus word consumer; slave = the receiver
    modport master (
        output dir, ser_valid, ser_in, out_ready,
`ifdef SHIFT_DESER_PARITY_EN
        input  parity_err,
`endif
        input  ser_ready, out_valid, y, busy
    );

    modport slave (
        input  dir, ser_valid, ser_in, out_ready,
`ifdef SHIFT_DESER_PARITY_EN
        output parity_err,
`endif
        output ser_ready, out_valid, y, busy
    );

endinterface

// File: rtl/shift_deser_bit_cnt.sv
// Bit counter for shift_deser: counts accepted data bits and flags the last one.
module shift_bit_cnt #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)   r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (inc) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(WIDTH - 1)) && inc;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver with per-word MSB/LSB-first order and valid/ready output.
// Define SHIFT_DESER_PARITY_EN to accept a trailing even-parity bit and report parity_err.
module shift_deser
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic         clk,
    input logic         rst_n,
    shift_deser_if.slave bus
);

    state_e           r_state, w_next;
    logic [WIDTH-1:0] r_shift, w_shift_nxt, r_y;
    logic             r_dir_q, w_dir;
    logic             w_ser_ready, w_out_valid, w_accept, w_inc, w_last;
    logic [CNT_W-1:0] w_cnt;
`ifdef SHIFT_DESER_PARITY_EN
    logic             r_parity_err;
`endif

    assign w_ser_ready = (r_state != HOLD);
    assign w_accept    = bus.ser_valid && w_ser_ready;
    assign w_inc       = w_accept && (r_state == IDLE || r_state == SHIFT);

    shift_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_inc),
        .clr  (w_last),
        .cnt  (w_cnt),
        .last (w_last)
    );

    // Bit order is taken live on the first bit and frozen in r_dir_q for the rest of the word.
    always_comb begin
        w_dir       = (r_state == IDLE) ? bus.dir : r_dir_q;
        w_shift_nxt = (w_dir == DIR_MSB_FIRST) ? {r_shift[WIDTH-2:0], bus.ser_in}
                                               : {bus.ser_in, r_shift[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:   if (w_accept) w_next = SHIFT;
`ifdef SHIFT_DESER_PARITY_EN
            SHIFT:  if (w_last) w_next = PARITY;
`else
            SHIFT:  if (w_last) w_next = HOLD;
`endif
            PARITY: if (w_accept) w_next = HOLD;
            HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_dir_q <= DIR_MSB_FIRST;
            r_y     <= '0;
        end else begin
            if (w_inc) begin
                r_shift <= w_shift_nxt;
                if (r_state == IDLE) r_dir_q <= bus.dir;
            end
`ifdef SHIFT_DESER_PARITY_EN
            if (r_state == PARITY && w_accept) r_y <= r_shift;
`else
            if (w_last) r_y <= w_shift_nxt;
`endif
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                             r_parity_err <= 1'b0;
        else if (r_state == PARITY && w_accept) r_parity_err <= (^r_shift) ^ bus.ser_in;
    end
    assign bus.parity_err = r_parity_err;
`endif

    // The count is non-zero exactly while a word is partly shifted in (state SHIFT).
    assign bus.busy      = (w_cnt != '0);
    assign bus.ser_ready = w_ser_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = r_y;

endmodule
